sram_req_tracker: RTL

Parametrised outstanding-request tracker that sits between a pipeline stage (fetch or exe/mem) and the SRAM-like req/addr_ok/data_ok bus. It replaces the ad-hoc single counter in the core top. It supports up to DEPTH in-order outstanding transactions, each carrying a tag. On a pipeline flush (exception or ertn), every response still in flight is silently discarded, so a cancelled access never reaches the pipeline.

---
 rtl/sram_req_tracker.sv | 119 +++++++++++
 1 files changed

// File: rtl/sram_req_tracker.sv
// Tracks up to DEPTH in-order outstanding SRAM-bus requests and returns each
// response with its tag; a flush marks everything in flight so those responses are dropped.
module sram_req_tracker #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,

  input  logic                up_req,
  input  logic                up_wr,
  input  logic [1:0]          up_size,
  input  logic [DATA_W/8-1:0] up_wstrb,
  input  logic [ADDR_W-1:0]   up_addr,
  input  logic [DATA_W-1:0]   up_wdata,
  input  logic [TAG_W-1:0]    up_tag,
  output logic                up_accept,

  output logic                sram_req,
  output logic                sram_wr,
  output logic [1:0]          sram_size,
  output logic [DATA_W/8-1:0] sram_wstrb,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic                sram_addr_ok,
  input  logic                sram_data_ok,
  input  logic [DATA_W-1:0]   sram_rdata,

  output logic                rsp_valid,
  output logic                rsp_wr,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [DATA_W-1:0]   rsp_rdata,

  output logic [CNT_W-1:0]    outstanding,
  output logic                full,
  output logic                busy,
  output logic                protocol_err
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] ent_wr;
  logic [DEPTH-1:0] ent_discard;
  logic [TAG_W-1:0] ent_tag [DEPTH];
  logic [DEPTH-1:0] occupied;
  logic             push;
  logic             pop;

  assign outstanding = count;
  assign full        = (count == CNT_W'(DEPTH));
  assign busy        = (count != '0);

  assign sram_req   = up_req & ~full & ~flush;
  assign up_accept  = sram_req & sram_addr_ok;
  assign sram_wr    = up_wr;
  assign sram_size  = up_size;
  assign sram_wstrb = up_wstrb;
  assign sram_addr  = up_addr;
  assign sram_wdata = up_wdata;

  assign push = up_accept;
  assign pop  = sram_data_ok & busy;

  assign rsp_valid = pop & ~ent_discard[rd_ptr] & ~flush;
  assign rsp_wr    = ent_wr[rd_ptr];
  assign rsp_tag   = ent_tag[rd_ptr];
  assign rsp_rdata = sram_rdata;

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      ent_wr       <= '0;
      ent_discard  <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_tag[i] <= '0;
      end
    end else begin
      if (flush) begin
        ent_discard <= ent_discard | occupied;
      end
      // flush gates sram_req, so push never overlaps the discard update above
      if (push) begin
        ent_wr[wr_ptr]      <= up_wr;
        ent_tag[wr_ptr]     <= up_tag;
        ent_discard[wr_ptr] <= 1'b0;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (sram_data_ok && !busy) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule
